ens_vote_argmax: RTL and testbench

ENS_VOTE_ARGMAX -- requirements
Module: ens_vote_argmax

---
 rtl/ens_vote_argmax.sv | 163 ++++++++++++++++
 tb/tb_ens_vote_argmax.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ens_vote_argmax.sv
// ens_vote_argmax: sums NUM_ENS member votes per class, then scans for the
// argmax (ties go to the lowest index) and presents it over a valid/ready port.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready accept one
// member's class words per beat; out_class/out_score/out_valid/out_ready
// return the winner. Define ENS_VOTE_TIE_FLAG_EN to add out_tie, which is set
// when another class has the same score as the winner.
module ens_vote_argmax #(
   parameter int NUM_CLASSES = 10,
   parameter int CLASS_BITS  = 1,
   parameter int NUM_ENS     = 4,
   localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
   localparam int SW = $clog2(NUM_ENS * ((1 << CLASS_BITS) - 1) + 1),
   localparam int EW = (NUM_ENS > 1) ? $clog2(NUM_ENS) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_CLASSES*CLASS_BITS-1:0] in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [CW-1:0]                     out_class,
   output logic [SW-1:0]                     out_score,
   output logic                              out_valid,
`ifdef ENS_VOTE_TIE_FLAG_EN
   output logic                              out_tie,
`endif
   input  logic                              out_ready
);

   typedef enum logic [1:0] {ACCUM, SCAN, OUT} state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   score_q [NUM_CLASSES];
   logic [SW-1:0]   score_d [NUM_CLASSES];
   logic [EW-1:0]   mem_q, mem_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   best_idx_q, best_idx_d;
   logic [SW-1:0]   best_score_q, best_score_d;
   logic [CW-1:0]   out_class_q, out_class_d;
   logic [SW-1:0]   out_score_q, out_score_d;
   logic            out_valid_q, out_valid_d;
   logic [SW-1:0]   cur_score;
`ifdef ENS_VOTE_TIE_FLAG_EN
   logic            tie_q, tie_d;
   logic            out_tie_q, out_tie_d;
`endif

   assign in_ready  = (state_q == ACCUM);
   assign out_class = out_class_q;
   assign out_score = out_score_q;
   assign out_valid = out_valid_q;
`ifdef ENS_VOTE_TIE_FLAG_EN
   assign out_tie   = out_tie_q;
`endif

   always_comb begin
      state_d      = state_q;
      score_d      = score_q;
      mem_d        = mem_q;
      idx_d        = idx_q;
      best_idx_d   = best_idx_q;
      best_score_d = best_score_q;
      out_class_d  = out_class_q;
      out_score_d  = out_score_q;
      out_valid_d  = out_valid_q;
      cur_score    = score_q[idx_q];
`ifdef ENS_VOTE_TIE_FLAG_EN
      tie_d        = tie_q;
      out_tie_d    = out_tie_q;
`endif
      unique case (state_q)
         ACCUM: begin
            if (in_valid) begin
               for (int k = 0; k < NUM_CLASSES; k++) begin
                  score_d[k] = score_q[k]
                     + SW'(in_data[k*CLASS_BITS +: CLASS_BITS]);
               end
               if (mem_q == EW'(NUM_ENS - 1)) begin
                  mem_d   = '0;
                  idx_d   = '0;
                  state_d = SCAN;
               end else begin
                  mem_d = mem_q + 1'b1;
               end
            end
         end
         SCAN: begin
            // Class 0 seeds the running best; later classes must beat it.
            if (idx_q == '0 || cur_score > best_score_q) begin
               best_idx_d   = idx_q;
               best_score_d = cur_score;
`ifdef ENS_VOTE_TIE_FLAG_EN
               tie_d        = 1'b0;
`endif
            end
`ifdef ENS_VOTE_TIE_FLAG_EN
            else if (cur_score == best_score_q) begin
               tie_d = 1'b1;
            end
`endif
            if (idx_q == CW'(NUM_CLASSES - 1)) begin
               idx_d   = '0;
               state_d = OUT;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         OUT: begin
            // First OUT cycle registers the result; later cycles wait.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_class_d = best_idx_q;
               out_score_d = best_score_q;
`ifdef ENS_VOTE_TIE_FLAG_EN
               out_tie_d   = tie_q;
`endif
            end else if (out_ready) begin
               out_valid_d  = 1'b0;
               best_idx_d   = '0;
               best_score_d = '0;
               for (int k = 0; k < NUM_CLASSES; k++) score_d[k] = '0;
`ifdef ENS_VOTE_TIE_FLAG_EN
               tie_d        = 1'b0;
`endif
               state_d      = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ACCUM;
         for (int k = 0; k < NUM_CLASSES; k++) score_q[k] <= '0;
         mem_q        <= '0;
         idx_q        <= '0;
         best_idx_q   <= '0;
         best_score_q <= '0;
         out_class_q  <= '0;
         out_score_q  <= '0;
         out_valid_q  <= 1'b0;
`ifdef ENS_VOTE_TIE_FLAG_EN
         tie_q        <= 1'b0;
         out_tie_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         score_q      <= score_d;
         mem_q        <= mem_d;
         idx_q        <= idx_d;
         best_idx_q   <= best_idx_d;
         best_score_q <= best_score_d;
         out_class_q  <= out_class_d;
         out_score_q  <= out_score_d;
         out_valid_q  <= out_valid_d;
`ifdef ENS_VOTE_TIE_FLAG_EN
         tie_q        <= tie_d;
         out_tie_q    <= out_tie_d;
`endif
      end
   end

endmodule

// File: tb/tb_ens_vote_argmax.sv
// tb_ens_vote_argmax: directed vectors for ens_vote_argmax at default
// parameters, with hand-computed class/score/latency expectations.
module tb_ens_vote_argmax;

   localparam int NC  = 10;
   localparam int LAT = 11;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NC-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    out_class;
   logic [2:0]    out_score;
   logic          out_valid;
   logic          out_ready = 1'b0;
`ifdef ENS_VOTE_TIE_FLAG_EN
   logic          out_tie;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_beat = 0;
   int hs_cyc = 0;

   ens_vote_argmax dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_class (out_class),
      .out_score (out_score),
      .out_valid (out_valid),
`ifdef ENS_VOTE_TIE_FLAG_EN
      .out_tie   (out_tie),
`endif
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [NC-1:0] oh(input int k);
      logic [NC-1:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Called just after a negedge; returns just after the next negedge
   // following the accepting edge.
   task automatic send_beat(input logic [NC-1:0] d);
      int n;
      in_data = d;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("beat_ready_timeout", 32'(n < 40), 32'd1);
      @(posedge clk);
      @(negedge clk);
      last_beat = cyc;
      in_valid = 1'b0;
   endtask

   task automatic get_result(input string tag, input int ec, input int es,
                             input int et, input int stall);
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_lat"}, 32'(cyc - last_beat), 32'(LAT));
      check({tag, "_class"}, 32'(out_class), 32'(ec));
      check({tag, "_score"}, 32'(out_score), 32'(es));
`ifdef ENS_VOTE_TIE_FLAG_EN
      check({tag, "_tie"}, 32'(out_tie), 32'(et));
`else
      if (et < 0) check({tag, "_tie_arg"}, 32'(et), 32'd0);
`endif
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_class"}, 32'(out_class), 32'(ec));
         check({tag, "_hold_score"}, 32'(out_score), 32'(es));
         check({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      hs_cyc = cyc;
      out_ready = 1'b0;
      check({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_hs_inrdy"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      do_reset();
      @(negedge clk);
      check("rst_inrdy", 32'(in_ready), 32'd1);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_class", 32'(out_class), 32'd0);
      check("rst_score", 32'(out_score), 32'd0);
`ifdef ENS_VOTE_TIE_FLAG_EN
      check("rst_tie", 32'(out_tie), 32'd0);
`endif

      // Unanimous class 7
      for (int i = 0; i < 4; i++) send_beat(oh(7));
      get_result("c7", 7, 4, 0, 0);

      // 3 and 5 tie at 2 -> lowest index wins
      send_beat(oh(3));
      send_beat(oh(5));
      send_beat(oh(5));
      send_beat(oh(3));
      get_result("tie35", 3, 2, 1, 0);

      // All-zero votes
      for (int i = 0; i < 4; i++) send_beat('0);
      get_result("zero", 0, 0, 1, 0);

      // Mixed votes and a multi-bit beat: class 6 = 3, class 1 = 2
      send_beat(oh(6));
      send_beat(oh(6) | oh(1));
      send_beat(oh(1));
      send_beat(oh(6));
      get_result("stall", 6, 3, 0, 5);

      // Residual class 6 score would win here if not cleared
      send_beat(oh(2));
      send_beat(oh(2));
      send_beat(oh(6));
      send_beat(oh(2));
      get_result("clean", 2, 3, 0, 0);

      // Reset mid-accumulation
      send_beat('1);
      send_beat('1);
      do_reset();
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (i % 4 == 0) check("abort_valid", 32'(out_valid), 32'd0);
      end
      check("abort_inrdy", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) send_beat(oh(9));
      get_result("c9", 9, 4, 0, 0);

      // Random gaps in ACCUM, then valid held high through SCAN/OUT
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send_beat(oh(5) | ((i == 2) ? oh(8) : '0));
      end
      in_data = oh(1);
      in_valid = 1'b1;
      get_result("gap", 5, 4, 0, 0);
      last_beat = hs_cyc + 4;
      get_result("held", 1, 4, 0, 0);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("held_idle_valid", 32'(out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
